// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder: one load/store at a time over req/ready,
// with programmable wait states and an error flag for misaligned or out-of-range addresses.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_err
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_W   = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic        ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_nxt;
  logic            r_we;
  logic [AW-1:0]   r_idx;
  logic [31:0]     r_wdata;
  logic            r_ready;
  logic            r_err;
  logic [31:0]     r_rdata;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_addr_ok;
  logic [AW-1:0]   w_in_idx;
  logic            w_capture;
  logic            w_access;
  logic            w_access_en;
  logic            w_reject;
  logic            w_acc_we;
  logic [AW-1:0]   w_acc_idx;
  logic [31:0]     w_acc_wdata;

  assign w_addr_ok   = (i_addr[1:0] == 2'b00) && (i_addr[31:2] < DEPTH_W);
  assign w_in_idx    = i_addr[AW+1:2];
  // Reset wins over a simultaneous clock edge, so no storage write may slip through.
  assign w_access_en = w_access & ~i_reset;

  // Next-state logic; the access operands come straight from the inputs on a zero-wait accept.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    w_reject    = 1'b0;
    w_acc_we    = r_we;
    w_acc_idx   = r_idx;
    w_acc_wdata = r_wdata;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          w_capture = 1'b1;
          if (!w_addr_ok) begin
            w_state_nxt = ST_RESP;
            w_reject    = 1'b1;
          end else if (ZERO_WAIT) begin
            w_state_nxt = ST_RESP;
            w_access    = 1'b1;
            w_acc_we    = i_we;
            w_acc_idx   = w_in_idx;
            w_acc_wdata = i_wdata;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WAIT_LOAD;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_RESP;
          w_access    = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Control state, captured request and registered response.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_we    <= i_we;
        r_idx   <= w_in_idx;
        r_wdata <= i_wdata;
      end
      r_ready <= (w_state_nxt == ST_RESP);
      if (w_access) begin
        r_err   <= 1'b0;
        r_rdata <= w_acc_we ? 32'd0 : r_mem[w_acc_idx];
      end else if (w_reject) begin
        r_err   <= 1'b1;
        r_rdata <= 32'd0;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_clk) begin
    if (w_access_en && w_acc_we) begin
      r_mem[w_acc_idx] <= w_acc_wdata;
    end
  end

  assign o_ready = r_ready;
  assign o_rdata = r_rdata;
  assign o_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: table of load/store vectors on a 2-wait-state instance,
// plus hand sequences for reset, aborts, ignored inputs and a zero-wait instance.
module tb_data_mem_responder;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req2 = 1'b0, we2 = 1'b0;
  logic [31:0] addr2 = 32'd0, wdata2 = 32'd0;
  logic        ready2, err2;
  logic [31:0] rdata2;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'd0, wdata0 = 32'd0;
  logic        ready0, err0;
  logic [31:0] rdata0;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[12];

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_req(req2), .i_we(we2), .i_addr(addr2),
    .i_wdata(wdata2), .o_ready(ready2), .o_rdata(rdata2), .o_err(err2)
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_req(req0), .i_we(we0), .i_addr(addr0),
    .i_wdata(wdata0), .o_ready(ready0), .o_rdata(rdata0), .o_err(err0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic pop_cmp(input string name, input logic [31:0] rd, input logic er);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_rdata"}, rd, e.rdata);
      chk({name, "_err"}, {31'd0, er}, {31'd0, e.err});
    end
  endtask

  // One transaction on the 2-wait-state instance, checking latency, data and pulse width.
  task automatic run2(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd,
                      input logic exp_err, input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    req2 = 1'b1; we2 = we; addr2 = addr; wdata2 = wdata;
    e.rdata = exp_rd; e.err = exp_err;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req2 = 1'b0;
    n = 1;
    while (!ready2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready2) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      chk({name, "_latency"}, n, lat);
      pop_cmp(name, rdata2, err2);
      @(negedge clk);
      chk({name, "_pulse_width"}, {31'd0, ready2}, 32'd0);
    end
  endtask

  // Reset asserted between clock edges must clear outputs immediately.
  task automatic mid_reset(input string name);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk({name, "_ready"}, {31'd0, ready2}, 32'd0);
    chk({name, "_err"}, {31'd0, err2}, 32'd0);
    chk({name, "_rdata"}, rdata2, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int   pulses;
    int   first;
    exp_t e;

    vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 3};
    vecs[1]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3};
    vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 3};
    vecs[3]  = '{1'b0, 32'h0000_0012, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
    vecs[4]  = '{1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};
    vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0BAD_F00D, 1'b0, 3};
    vecs[6]  = '{1'b1, 32'h0000_00FC, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 3};
    vecs[7]  = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 3};
    vecs[8]  = '{1'b0, 32'h0000_0101, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
    vecs[9]  = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
    vecs[10] = '{1'b1, 32'h0000_0020, 32'h5555_5555, 32'h0000_0000, 1'b0, 3};
    vecs[11] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 3};

    #1;
    chk("reset_ready", {31'd0, ready2}, 32'd0);
    chk("reset_err", {31'd0, err2}, 32'd0);
    chk("reset_rdata", rdata2, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run2($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
           vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].lat);
    end
    mid_reset("midrst_rdata");
    run2("err_before_rst", 1'b0, 32'h0000_0012, 32'd0, 32'd0, 1'b1, 1);
    mid_reset("midrst_err");

    // Store aborted by reset during WAIT must leave the old word intact.
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h0000_0020; wdata2 = 32'hAAAA_AAAA;
    @(posedge clk);
    @(negedge clk);
    req2 = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", {31'd0, ready2}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ready2) pulses++;
    end
    chk("abort_no_ready", pulses, 0);
    run2("abort_load", 1'b0, 32'h0000_0020, 32'd0, 32'h5555_5555, 1'b0, 3);

    // Inputs changed and req dropped during WAIT are ignored.
    run2("ign_pre_store", 1'b1, 32'h0000_0034, 32'h3333_3333, 32'd0, 1'b0, 3);
    @(negedge clk);
    req2 = 1'b1; we2 = 1'b1; addr2 = 32'h0000_0030; wdata2 = 32'h1111_1111;
    e.rdata = 32'd0; e.err = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    req2 = 1'b0; we2 = 1'b0; addr2 = 32'h0000_0034; wdata2 = 32'h2222_2222;
    pulses = 0;
    first  = 0;
    for (int k = 1; k <= 8; k++) begin
      if (ready2) begin
        pulses++;
        if (first == 0) begin
          first = k;
          pop_cmp("ign_resp", rdata2, err2);
        end
      end
      @(negedge clk);
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_latency", first, 3);
    run2("ign_load30", 1'b0, 32'h0000_0030, 32'd0, 32'h1111_1111, 1'b0, 3);
    run2("ign_load34", 1'b0, 32'h0000_0034, 32'd0, 32'h3333_3333, 1'b0, 3);

    // Zero wait states: req held high gives a ready pulse every second cycle.
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0000_00FC; wdata0 = 32'h1234_5678;
    e.rdata = 32'd0; e.err = 1'b0;
    sb.push_back(e);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk($sformatf("zw_ready%0d", k), {31'd0, ready0}, {31'd0, logic'(k % 2)});
      if (ready0) pop_cmp($sformatf("zw_resp%0d", k), rdata0, err0);
      if (k == 1) begin
        we0 = 1'b0;
        e.rdata = 32'h1234_5678; e.err = 1'b0;
        sb.push_back(e);
        sb.push_back(e);
      end
      if (k == 6) req0 = 1'b0;
    end
    @(negedge clk);
    chk("zw_idle", {31'd0, ready0}, 32'd0);
    chk("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
